arbiter_rr4: RTL and testbench

- Four-requester round-robin arbiter that sequences access to one shared resource.
- Registers a 2-bit winner index and drives it through the team's 2-to-4 decoder to produce a one-hot grant vector.
- Grants are held until the owner releases or a hold limit expires; priority then rotates.
- Sits between up to four requesting blocks and the shared datapath; the one-hot grant is used directly as that datapath's select/enable.

---
 rtl/arbiter_pkg.sv | 31 +++
 rtl/Decoder2x4.sv | 13 +
 rtl/arbiter_rr4.sv | 82 ++++++++
 tb/tb_arbiter_rr4.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
// Includes the rotating-priority pick used by arbiter_rr4.
package arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int N_REQ        = 4;
  localparam int HOLD_MAX_DEF = 8;

  // First set request bit when scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req,
                                         input logic [1:0]       ptr);
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/Decoder2x4.sv
// 2-to-4 decoder with active-high enable; output is one-hot or all zero.
module Decoder2x4 (
  input  logic [1:0] A,
  input  logic       E,
  output logic [3:0] D
);

  always_comb begin
    D = '0;
    if (E) D[A] = 1'b1;
  end

endmodule

// File: rtl/arbiter_rr4.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// Handshake: a requester holds req high while it wants the resource; gnt[i] is its
// ownership window, and dropping req[i] ends the grant at the next edge.
module arbiter_rr4
  import arbiter_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             gnt_valid
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [1:0]       winner;

  assign winner = rr_pick(req, ptr_q);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      gnt_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  // Releasing always passes through IDLE, which gives the one-cycle turnaround.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_id_d = gnt_id_q;
    unique case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          state_d  = GRANT;
          gnt_id_d = winner;
          ptr_d    = winner + 2'd1;
          cnt_d    = '0;
        end
      end
      GRANT: begin
        if (!req[gnt_id_q] || (cnt_q == HOLD_LAST)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // gnt_valid mirrors the FSM state, so it doubles as the state observation point.
  always_comb begin
    gnt_valid = (state_q == GRANT);
    gnt_id    = gnt_id_q;
  end

  Decoder2x4 u_dec (
    .A (gnt_id_q),
    .E (gnt_valid),
    .D (gnt)
  );

endmodule

// File: tb/tb_arbiter_rr4.sv
// Bench for arbiter_rr4: directed table, hand-written corner sequences, and random
// traffic against a reference model, on HOLD_MAX=8 and HOLD_MAX=1 instances.
module tb_arbiter_rr4;

  logic       clk = 1'b0;
  logic       nrst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt8, gnt1;
  logic [1:0] id8, id1;
  logic       v8, v1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arbiter_rr4 #(.HOLD_MAX(8), .CNT_W(4)) dut8 (
    .clk(clk), .nrst(nrst), .en(en), .req(req),
    .gnt(gnt8), .gnt_id(id8), .gnt_valid(v8)
  );

  arbiter_rr4 #(.HOLD_MAX(1), .CNT_W(4)) dut1 (
    .clk(clk), .nrst(nrst), .en(en), .req(req),
    .gnt(gnt1), .gnt_id(id1), .gnt_valid(v1)
  );

  // Reference model: who owns the resource, for how many cycles so far, and
  // which requester is first in line next.
  int hold_of[2] = '{8, 1};
  bit m_own[2];
  int m_id[2];
  int m_ptr[2];
  int m_held[2];

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
  } vec_t;

  vec_t tbl[11];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = 0;
      m_id[k]   = 0;
      m_ptr[k]  = 0;
      m_held[k] = 0;
    end
  endtask

  task automatic model_step();
    if (!nrst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (m_own[k]) begin
        if (!req[m_id[k]] || m_held[k] == hold_of[k]) m_own[k] = 0;
        else m_held[k]++;
      end else if (en && req != 4'b0000) begin
        for (int j = 0; j < 4; j++) begin
          int idx;
          idx = (m_ptr[k] + j) % 4;
          if (!m_own[k] && req[idx]) begin
            m_own[k]  = 1;
            m_id[k]   = idx;
            m_ptr[k]  = (idx + 1) % 4;
            m_held[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic expect_eq(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg0, eg1;
    eg0 = m_own[0] ? (4'b0001 << m_id[0]) : 4'b0000;
    eg1 = m_own[1] ? (4'b0001 << m_id[1]) : 4'b0000;
    expect_eq({tag, " gnt8"}, 8'(gnt8), 8'(eg0));
    expect_eq({tag, " id8"},  8'(id8),  8'(m_id[0]));
    expect_eq({tag, " v8"},   8'(v8),   8'(m_own[0]));
    expect_eq({tag, " gnt1"}, 8'(gnt1), 8'(eg1));
    expect_eq({tag, " id1"},  8'(id1),  8'(m_id[1]));
    expect_eq({tag, " v1"},   8'(v1),   8'(m_own[1]));
  endtask

  task automatic step_check(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int held;
    int ph, per;
    logic [3:0] eg;

    // Reset holds every output at zero even with all requests and enable high.
    nrst = 1'b0;
    en   = 1'b1;
    req  = 4'b1111;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      expect_eq("rst gnt8", 8'(gnt8), 8'h0);
      expect_eq("rst v8",   8'(v8),   8'h0);
      expect_eq("rst id8",  8'(id8),  8'h0);
      expect_eq("rst gnt1", 8'(gnt1), 8'h0);
    end
    nrst = 1'b1;
    req  = 4'b0000;
    @(negedge clk);

    // Directed table starting from ptr=0.
    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
    tbl[1]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
    tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0};
    tbl[3]  = '{4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[4]  = '{4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[5]  = '{4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[6]  = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1};
    tbl[8]  = '{4'b1101, 1'b0, 4'b0000, 2'd1, 1'b0};
    tbl[9]  = '{4'b1101, 1'b1, 4'b0100, 2'd2, 1'b1};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0};
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req;
      en  = tbl[i].en;
      step_check($sformatf("tbl%0d model", i));
      expect_eq($sformatf("tbl%0d gnt", i),   8'(gnt8), 8'(tbl[i].gnt));
      expect_eq($sformatf("tbl%0d id", i),    8'(id8),  8'(tbl[i].id));
      expect_eq($sformatf("tbl%0d valid", i), 8'(v8),   8'(tbl[i].valid));
    end

    // Fairness with forced release: 8-cycle grants rotating 0,1,2,3,0 with one gap each.
    do_reset();
    req = 4'b1111;
    en  = 1'b1;
    for (int t = 1; t <= 37; t++) begin
      step_check("fair model");
      ph  = (t - 1) % 9;
      per = (t - 1) / 9;
      eg  = (ph < 8) ? (4'b0001 << (per % 4)) : 4'b0000;
      expect_eq($sformatf("fair t%0d", t), 8'(gnt8), 8'(eg));
    end

    // Asynchronous reset while requester 1 owns the grant.
    do_reset();
    req = 4'b0010;
    step_check("areset pre");
    expect_eq("areset owned", 8'(gnt8), 8'b0010);
    #1 nrst = 1'b0;
    model_reset();
    #1;
    expect_eq("areset gnt8", 8'(gnt8), 8'h0);
    expect_eq("areset v8",   8'(v8),   8'h0);
    expect_eq("areset id8",  8'(id8),  8'h0);
    expect_eq("areset gnt1", 8'(gnt1), 8'h0);
    @(negedge clk);
    nrst = 1'b1;
    req  = 4'b1111;
    step_check("areset post");
    expect_eq("areset first", 8'(gnt8), 8'b0001);

    // Enable gating: no grant while low, in-flight grant unaffected.
    do_reset();
    en  = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      step_check("en0 model");
      expect_eq("en0 gnt", 8'(gnt8), 8'h0);
    end
    en = 1'b1;
    step_check("en1 model");
    expect_eq("en1 gnt", 8'(gnt8), 8'b0001);
    en   = 1'b0;
    held = 1;
    for (int c = 0; c < 20 && gnt8 != 4'b0000; c++) begin
      step_check("en_drop model");
      if (gnt8 != 4'b0000) held++;
    end
    expect_eq("en_drop held", 8'(held), 8'd8);
    for (int c = 0; c < 5; c++) begin
      step_check("en_drop idle model");
      expect_eq("en_drop idle", 8'(gnt8), 8'h0);
    end

    // Random traffic with sticky requests and occasional mid-cycle resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 9) != 0);
      step_check("rand");
      if ($urandom_range(0, 399) == 0) begin
        #1 nrst = 1'b0;
        model_reset();
        #1 check_model("rand areset");
        @(negedge clk);
        nrst = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
